// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, bus layouts
// and load_type codes used by the EX, MEM and WB stages.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 74;
    localparam int MS_TO_WS_BUS_WD = 70;

    // Codes 101-111 are not listed and fall back to full-word loads.
    typedef enum logic [2:0] {
        LOAD_W  = 3'b000,
        LOAD_B  = 3'b001,
        LOAD_BU = 3'b010,
        LOAD_H  = 3'b011,
        LOAD_HU = 3'b100
    } load_type_e;

    typedef struct packed {
        logic [2:0]  load_type;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the addressed byte or halfword from the
// SRAM word and sign- or zero-extends it according to load_type.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  load_type,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned word and halfword loads are not trapped; they simply use
    // the word as-is or the half picked by off[1].
    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase

        half_sel = off[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (load_type)
            LOAD_B:  data = {{24{byte_sel[7]}}, byte_sel};
            LOAD_BU: data = {24'b0, byte_sel};
            LOAD_H:  data = {{16{half_sel[15]}}, half_sel};
            LOAD_HU: data = {16'b0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the 5-stage pipeline: registers the EX->MEM bus,
// holds SRAM read data across WB stalls and forms the MEM->WB bus.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic [5:0]                 reg_code_MS,
    output logic [31:0]                ms_fwd_data
);

    logic        ms_valid;
    logic        ms_ready_go;
    logic        accept;
    es_to_ms_t   ms_bus;
    logic        rd_first;
    logic [31:0] rdata_hold;
    logic [31:0] rdata_eff;
    logic [31:0] load_data;
    logic [31:0] final_result;
    ms_to_ws_t   ws_bus;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // The bus register carries no reset; its contents only matter while
    // ms_valid is high.
    always_ff @(posedge clk) begin
        if (accept) begin
            ms_bus <= es_to_ms_t'(es_to_ms_bus);
        end
    end

    // SRAM data is only valid in an instruction's first MEM cycle, so it is
    // captured then and replayed from rdata_hold for the rest of a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_first <= 1'b0;
        end else begin
            rd_first <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_first) begin
            rdata_hold <= data_sram_rdata;
        end
    end

    assign rdata_eff = rd_first ? data_sram_rdata : rdata_hold;

    load_align u_load_align (
        .rdata     (rdata_eff),
        .off       (ms_bus.alu_result[1:0]),
        .load_type (ms_bus.load_type),
        .data      (load_data)
    );

    assign final_result = ms_bus.res_from_mem ? load_data : ms_bus.alu_result;

    assign ws_bus.gr_we        = ms_bus.gr_we;
    assign ws_bus.dest         = ms_bus.dest;
    assign ws_bus.final_result = final_result;
    assign ws_bus.pc           = ms_bus.pc;
    assign ms_to_ws_bus        = ws_bus;

    // dest is masked when the stage is empty so the code reads zero after
    // reset even though the bus register itself is not reset.
    assign reg_code_MS = {ms_valid && ms_bus.gr_we, ms_valid ? ms_bus.dest : 5'b0};
    assign ms_fwd_data = final_result;

endmodule
